// File: rtl/cond_unit_pkg.sv
// rtl/cond_unit_pkg.sv - shared CPU constants: condition codes, flag bit indices, alu_ctl encodings
package cond_unit_pkg;

  // ARM condition field encodings (instr[31:28])
  typedef enum logic [3:0] {
    COND_EQ  = 4'b0000,
    COND_NE  = 4'b0001,
    COND_CS  = 4'b0010,
    COND_CC  = 4'b0011,
    COND_MI  = 4'b0100,
    COND_PL  = 4'b0101,
    COND_VS  = 4'b0110,
    COND_VC  = 4'b0111,
    COND_HI  = 4'b1000,
    COND_LS  = 4'b1001,
    COND_GE  = 4'b1010,
    COND_LT  = 4'b1011,
    COND_GT  = 4'b1100,
    COND_LE  = 4'b1101,
    COND_AL  = 4'b1110,
    COND_UNC = 4'b1111
  } cond_e;

  // ALU control encodings; ALU_ADC consumes the registered carry
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_ORR = 3'b011,
    ALU_ADC = 3'b100
  } alu_ctl_e;

  // Bit positions within the {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_unit_if.sv
// rtl/cond_unit_if.sv - decoder/ALU side bundle feeding the condition unit
interface cond_unit_if;
  logic       en;
  logic [3:0] cond;
  logic [3:0] alu_flags;
  logic [1:0] flag_w;
  logic       pc_s;
  logic       reg_w;
  logic       mem_w;
  logic       no_write;
  logic       pc_src;
  logic       reg_write;
  logic       mem_write;
  logic       cond_ex;
  logic [3:0] flags;
  logic       carry;

  modport master (
    output en, cond, alu_flags, flag_w, pc_s, reg_w, mem_w, no_write,
    input  pc_src, reg_write, mem_write, cond_ex, flags, carry
  );

  modport slave (
    input  en, cond, alu_flags, flag_w, pc_s, reg_w, mem_w, no_write,
    output pc_src, reg_write, mem_write, cond_ex, flags, carry
  );
endinterface

// File: rtl/cond_unit_check.sv
// rtl/cond_unit_check.sv - combinational ARM condition evaluation against current flags
module cond_check
  import cond_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Decode the condition field; 1111 behaves as always
  always_comb begin
    cond_ex = 1'b1;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      default: cond_ex = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - flag registers and condition gating of datapath write enables
module cond_unit
  import cond_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  cond_unit_if.slave  bus
);

  logic [1:0] nz_q, nz_d;
  logic [1:0] cv_q, cv_d;
  logic [3:0] flags_cur;
  logic       cond_ex;
  logic       issue;

  assign flags_cur = {nz_q, cv_q};

  cond_check u_cond_check (
    .cond    (bus.cond),
    .flags   (flags_cur),
    .cond_ex (cond_ex)
  );

  // An instruction only takes effect when it is issued and its condition passes
  assign issue = bus.en & cond_ex;

  // Next-state for the two flag halves; each half updates independently
  always_comb begin
    nz_d = nz_q;
    cv_d = cv_q;
    if (issue && bus.flag_w[1]) nz_d = bus.alu_flags[FLAG_N:FLAG_Z];
    if (issue && bus.flag_w[0]) cv_d = bus.alu_flags[FLAG_C:FLAG_V];
  end

  // N,Z register; reset clears it regardless of clock and enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) nz_q <= 2'b00;
    else       nz_q <= nz_d;
  end

  // C,V register; reset clears it regardless of clock and enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cv_q <= 2'b00;
    else       cv_q <= cv_d;
  end

  assign bus.cond_ex   = cond_ex;
  assign bus.reg_write = bus.reg_w & cond_ex & ~bus.no_write & bus.en;
  assign bus.mem_write = bus.mem_w & cond_ex & bus.en;
  assign bus.pc_src    = bus.pc_s & cond_ex & bus.en;
  assign bus.flags     = flags_cur;
  assign bus.carry     = flags_cur[FLAG_C];

endmodule

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 The module SHALL have one clock and asynchronous, active-high reset: clk  input  1  rising-edge clock; reset  input  1  async active-high reset.
REQ-002 Input en  1: instruction-valid/advance; 0 = stall, hold all state.
REQ-003 Input cond  4: ARM condition field, instr[31:28].
REQ-004 Input alu_flags  4: ALU result flags {N,Z,C,V}, bit 3 = N.
REQ-005 Input flag_w  2: AluDecoder flag-write request; [1] = write N,Z; [0] = write C,V.
REQ-006 Inputs pc_s, reg_w, mem_w, no_write  1 each: main-decoder requests; no_write from AluDecoder (CMP/CMN/TST/TEQ).
REQ-007 Outputs pc_src, reg_write, mem_write  1 each: gated write enables to datapath.
REQ-008 Output cond_ex  1: condition-passed indication for current instruction.
REQ-009 Output flags  4: registered {N,Z,C,V}.
REQ-010 Output carry  1: registered C, carry-in for ADC (alu_ctl 100).

Function
REQ-011 cond_ex SHALL be combinational from cond and registered flags: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 1 (treated as AL).
REQ-012 reg_write SHALL = reg_w & cond_ex & !no_write & en.
REQ-013 mem_write SHALL = mem_w & cond_ex & en; pc_src SHALL = pc_s & cond_ex & en.
REQ-014 On rising clk with en=1, cond_ex=1, flag_w[1]=1: flags N,Z SHALL load alu_flags[3:2].
REQ-015 On rising clk with en=1, cond_ex=1, flag_w[0]=1: flags C,V SHALL load alu_flags[1:0].
REQ-016 flag_w halves SHALL be independent; flag_w=10 SHALL leave C,V unchanged (logical ops).
REQ-017 Flags SHALL hold when en=0, cond_ex=0, or flag_w=00.
REQ-018 Latency: flag update visible on flags/carry/cond_ex one cycle after the setting edge; an instruction never sees its own flag update.
REQ-019 Back-to-back CMP then conditional instruction SHALL evaluate against the CMP result with zero bubbles.
REQ-020 carry SHALL always equal flags[1].
REQ-021 A failed condition SHALL suppress all writes and all flag updates for that instruction.

Reset
REQ-022 reset=1 SHALL clear flags to 0000 asynchronously, independent of clk and en.
REQ-023 After reset: carry=0; with cond=0000 cond_ex=0, with cond=0001 cond_ex=1.
REQ-024 Reset asserted in the same cycle as a flag-setting instruction SHALL win; flags remain 0000.
REQ-025 Gated outputs SHALL remain combinational and follow REQ-012/013 from reset flag values during reset.

Structure
REQ-026 Condition-code constants (EQ..AL) and flag bit indices SHALL live in the shared CPU package alongside the alu_ctl encodings.
REQ-027 A single sub-module cond_check (cond, flags -> cond_ex, purely combinational) SHALL be instantiated; flag registers in cond_unit.
REQ-028 Flag register SHALL be split into NZ and CV 2-bit enabled registers.

Verification
REQ-029 Reset then cond=0000, reg_w=1 -> cond_ex=0, reg_write=0; cond=0001 -> reg_write=1.
REQ-030 CMP: cond=1110, flag_w=11, no_write=1, reg_w=1, alu_flags=0110 -> reg_write=0; next cycle flags=0110, EQ cond_ex=1, carry=1.
REQ-031 AND-S: flags=0110, flag_w=10, alu_flags=1001 -> flags=1010 (C,V kept).
REQ-032 Failed condition: flags=0100, cond=0001, flag_w=11, alu_flags=1000, mem_w=1 -> mem_write=0, flags stay 0100.
REQ-033 Stall: en=0, flag_w=11, alu_flags=1111 -> flags unchanged, all write outputs 0.
REQ-034 Signed compares: flags N=1,V=0,Z=0 -> LT=1, GE=0, GT=0, LE=1; HI with C=1,Z=0 -> 1; sweep all 16 cond codes vs all 16 flag values against a reference model.
